// File: rtl/spu_dual_issue_scheduler_pkg.sv
// Shared types and constants for the SPU dual-issue scheduler and its scoreboard.
// The hazard helper functions are kept here so the issue logic reads as plain boolean terms.
package spu_dual_issue_scheduler_pkg;

    localparam int NUM_REGS       = 128;
    localparam int REG_ADDR_WIDTH = 7;
    localparam int LAT_WIDTH      = 3;
    localparam int STALL_CNT_W    = 16;

    localparam logic EVEN_PIPE = 1'b0;
    localparam logic ODD_PIPE  = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PAIR  = 2'd1,
        ONE   = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                      pipe;
        logic                      wr;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] ra;
        logic [REG_ADDR_WIDTH-1:0] rb;
        logic [REG_ADDR_WIDTH-1:0] rc;
        logic [2:0]                src_use;
        logic [LAT_WIDTH-1:0]      lat;
        logic                      is_branch;
    } inst_desc_t;

    // True when the consumer reads, through any enabled port, the producer's destination.
    function automatic logic raw_hit(input inst_desc_t prod, input inst_desc_t cons);
        raw_hit = prod.wr & ((cons.src_use[2] & (cons.ra == prod.rt)) |
                             (cons.src_use[1] & (cons.rb == prod.rt)) |
                             (cons.src_use[0] & (cons.rc == prod.rt)));
    endfunction

    // True when both instructions write the same destination register.
    function automatic logic waw_hit(input inst_desc_t a, input inst_desc_t b);
        waw_hit = a.wr & b.wr & (a.rt == b.rt);
    endfunction

endpackage

// File: rtl/spu_dual_issue_scheduler_if.sv
// Decode-to-issue bundle: the instruction pair handshake, flush and the issue steering outputs.
interface spu_dual_issue_scheduler_if;
    import spu_dual_issue_scheduler_pkg::*;

    logic                      pair_valid;
    logic                      pair_ready;
    logic                      inst0_pipe;
    logic                      inst0_wr;
    logic [REG_ADDR_WIDTH-1:0] inst0_rt;
    logic [REG_ADDR_WIDTH-1:0] inst0_ra;
    logic [REG_ADDR_WIDTH-1:0] inst0_rb;
    logic [REG_ADDR_WIDTH-1:0] inst0_rc;
    logic [2:0]                inst0_src_use;
    logic [LAT_WIDTH-1:0]      inst0_lat;
    logic                      inst0_is_branch;
    logic                      inst1_pipe;
    logic                      inst1_wr;
    logic [REG_ADDR_WIDTH-1:0] inst1_rt;
    logic [REG_ADDR_WIDTH-1:0] inst1_ra;
    logic [REG_ADDR_WIDTH-1:0] inst1_rb;
    logic [REG_ADDR_WIDTH-1:0] inst1_rc;
    logic [2:0]                inst1_src_use;
    logic [LAT_WIDTH-1:0]      inst1_lat;
    logic                      flush;
    logic                      issue_even_vld;
    logic                      issue_even_sel;
    logic                      issue_odd_vld;
    logic                      issue_odd_sel;
    logic                      br_first_isntr;
    logic [STALL_CNT_W-1:0]    stall_cycles;

    modport master (
        output pair_valid, inst0_pipe, inst0_wr, inst0_rt, inst0_ra, inst0_rb, inst0_rc,
               inst0_src_use, inst0_lat, inst0_is_branch, inst1_pipe, inst1_wr, inst1_rt,
               inst1_ra, inst1_rb, inst1_rc, inst1_src_use, inst1_lat, flush,
        input  pair_ready, issue_even_vld, issue_even_sel, issue_odd_vld, issue_odd_sel,
               br_first_isntr, stall_cycles
    );

    modport slave (
        input  pair_valid, inst0_pipe, inst0_wr, inst0_rt, inst0_ra, inst0_rb, inst0_rc,
               inst0_src_use, inst0_lat, inst0_is_branch, inst1_pipe, inst1_wr, inst1_rt,
               inst1_ra, inst1_rb, inst1_rc, inst1_src_use, inst1_lat, flush,
        output pair_ready, issue_even_vld, issue_even_sel, issue_odd_vld, issue_odd_sel,
               br_first_isntr, stall_cycles
    );

endinterface

// File: rtl/spu_dual_issue_scheduler_scoreboard.sv
// Per-register pending-write down-counters with two issue-time set ports and six source ready ports.
module spu_scoreboard
    import spu_dual_issue_scheduler_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     set_en,
    input  logic [1:0][REG_ADDR_WIDTH-1:0] set_addr,
    input  logic [1:0][LAT_WIDTH-1:0]      set_lat,
    input  logic [5:0][REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [5:0]                     rd_ready
);

    logic [LAT_WIDTH-1:0] busy_cnt_r [NUM_REGS];

    // Counter update: an issuing writer's load beats the per-cycle drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_cnt_r[i] <= {LAT_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_en[1] && (set_addr[1] == REG_ADDR_WIDTH'(i))) begin
                    busy_cnt_r[i] <= set_lat[1];
                end else if (set_en[0] && (set_addr[0] == REG_ADDR_WIDTH'(i))) begin
                    busy_cnt_r[i] <= set_lat[0];
                end else if (busy_cnt_r[i] != {LAT_WIDTH{1'b0}}) begin
                    busy_cnt_r[i] <= busy_cnt_r[i] - {{(LAT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    busy_cnt_r[i] <= {LAT_WIDTH{1'b0}};
                end
            end
        end
    end

    // Source ready lookup against the current counters.
    always_comb begin
        rd_ready = 6'b000000;
        for (int p = 0; p < 6; p++) begin
            rd_ready[p] = (busy_cnt_r[rd_addr[p]] == {LAT_WIDTH{1'b0}});
        end
    end

endmodule

// File: rtl/spu_dual_issue_scheduler.sv
// Issue stage: holds one decoded pair, checks scoreboard and intra-pair hazards,
// and steers the instructions in program order to the even/odd pipes.
module spu_dual_issue_scheduler
    import spu_dual_issue_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    spu_dual_issue_scheduler_if.slave bus
);

    sched_state_t              state_r;
    sched_state_t              state_nxt_s;
    inst_desc_t                inst0_r;
    inst_desc_t                inst1_r;
    inst_desc_t                in0_s;
    inst_desc_t                in1_s;
    logic [STALL_CNT_W-1:0]    stall_cnt_r;
    logic [5:0][REG_ADDR_WIDTH-1:0] rd_addr_s;
    logic [5:0]                rd_ready_s;
    logic [1:0]                set_en_s;
    logic [1:0][REG_ADDR_WIDTH-1:0] set_addr_s;
    logic [1:0][LAT_WIDTH-1:0] set_lat_s;
    logic                      rdy0_s;
    logic                      rdy1_s;
    logic                      i0_go_s;
    logic                      i1_go_s;
    logic                      all_issue_s;
    logic                      pair_ready_s;
    logic                      accept_s;
    logic                      even_vld_s;
    logic                      even_sel_s;
    logic                      odd_vld_s;
    logic                      odd_sel_s;
    logic                      br_first_s;

    assign in0_s = '{pipe: bus.inst0_pipe, wr: bus.inst0_wr, rt: bus.inst0_rt, ra: bus.inst0_ra,
                     rb: bus.inst0_rb, rc: bus.inst0_rc, src_use: bus.inst0_src_use,
                     lat: bus.inst0_lat, is_branch: bus.inst0_is_branch};
    assign in1_s = '{pipe: bus.inst1_pipe, wr: bus.inst1_wr, rt: bus.inst1_rt, ra: bus.inst1_ra,
                     rb: bus.inst1_rb, rc: bus.inst1_rc, src_use: bus.inst1_src_use,
                     lat: bus.inst1_lat, is_branch: 1'b0};

    assign rd_addr_s  = {inst1_r.rc, inst1_r.rb, inst1_r.ra, inst0_r.rc, inst0_r.rb, inst0_r.ra};
    assign set_en_s   = {i1_go_s & inst1_r.wr, i0_go_s & inst0_r.wr};
    assign set_addr_s = {inst1_r.rt, inst0_r.rt};
    assign set_lat_s  = {inst1_r.lat, inst0_r.lat};

    spu_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en_s),
        .set_addr (set_addr_s),
        .set_lat  (set_lat_s),
        .rd_addr  (rd_addr_s),
        .rd_ready (rd_ready_s)
    );

    assign rdy0_s = (~inst0_r.src_use[2] | rd_ready_s[0]) & (~inst0_r.src_use[1] | rd_ready_s[1]) &
                    (~inst0_r.src_use[0] | rd_ready_s[2]);
    assign rdy1_s = (~inst1_r.src_use[2] | rd_ready_s[3]) & (~inst1_r.src_use[1] | rd_ready_s[4]) &
                    (~inst1_r.src_use[0] | rd_ready_s[5]);

    // Issue decision: inst1 may only join inst0 when pipes differ and no intra-pair hazard exists.
    always_comb begin
        i0_go_s     = 1'b0;
        i1_go_s     = 1'b0;
        all_issue_s = 1'b0;
        if (!reset || bus.flush) begin
            all_issue_s = 1'b0;
        end else begin
            case (state_r)
                PAIR: begin
                    i0_go_s     = rdy0_s;
                    i1_go_s     = rdy0_s & (inst1_r.pipe != inst0_r.pipe) & rdy1_s &
                                  ~raw_hit(inst0_r, inst1_r) & ~waw_hit(inst0_r, inst1_r);
                    all_issue_s = i1_go_s;
                end
                ONE: begin
                    i1_go_s     = rdy1_s;
                    all_issue_s = rdy1_s;
                end
                default: begin
                    all_issue_s = 1'b0;
                end
            endcase
        end
    end

    // Pipe steering, handshake and next-state selection.
    always_comb begin
        even_vld_s   = 1'b0;
        even_sel_s   = 1'b0;
        odd_vld_s    = 1'b0;
        odd_sel_s    = 1'b0;
        state_nxt_s  = state_r;
        if (i0_go_s) begin
            if (inst0_r.pipe == EVEN_PIPE) begin
                even_vld_s = 1'b1;
            end else begin
                odd_vld_s = 1'b1;
            end
        end else begin
            even_sel_s = 1'b0;
        end
        if (i1_go_s) begin
            if (inst1_r.pipe == EVEN_PIPE) begin
                even_vld_s = 1'b1;
                even_sel_s = 1'b1;
            end else begin
                odd_vld_s = 1'b1;
                odd_sel_s = 1'b1;
            end
        end else begin
            odd_sel_s = 1'b0;
        end
        br_first_s   = i0_go_s & i1_go_s & inst0_r.is_branch;
        pair_ready_s = reset & ~bus.flush & ((state_r == EMPTY) | all_issue_s);
        accept_s     = bus.pair_valid & pair_ready_s;
        if (!reset || bus.flush) begin
            state_nxt_s = EMPTY;
        end else if (accept_s) begin
            state_nxt_s = PAIR;
        end else begin
            case (state_r)
                PAIR:    state_nxt_s = i1_go_s ? EMPTY : (i0_go_s ? ONE : PAIR);
                ONE:     state_nxt_s = i1_go_s ? EMPTY : ONE;
                default: state_nxt_s = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding register for the accepted pair.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst0_r <= '0;
            inst1_r <= '0;
        end else if (accept_s) begin
            inst0_r <= in0_s;
            inst1_r <= in1_s;
        end else begin
            inst0_r <= inst0_r;
            inst1_r <= inst1_r;
        end
    end

    // Saturating count of cycles with held work that issued nothing; flush cycles are excluded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if ((state_r != EMPTY) && !bus.flush && !i0_go_s && !i1_go_s &&
                     (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.pair_ready     = pair_ready_s;
    assign bus.issue_even_vld = even_vld_s;
    assign bus.issue_even_sel = even_sel_s;
    assign bus.issue_odd_vld  = odd_vld_s;
    assign bus.issue_odd_sel  = odd_sel_s;
    assign bus.br_first_isntr = br_first_s;
    assign bus.stall_cycles   = stall_cnt_r;

endmodule

// File: tb/tb_spu_dual_issue_scheduler.sv
// Directed bench for the dual-issue scheduler: inputs change at the falling edge and
// outputs are compared 1ns later, i.e. within the decision cycle before the next rising edge.
module tb_spu_dual_issue_scheduler;
    import spu_dual_issue_scheduler_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    spu_dual_issue_scheduler_if bus ();

    spu_dual_issue_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every handshake/issue output of the current cycle.
    task automatic chk_iss(input string tag, input logic ev, input logic es, input logic ov,
                           input logic os, input logic br, input logic pr);
        chk({tag, ".even_vld"}, {15'd0, bus.issue_even_vld}, {15'd0, ev});
        chk({tag, ".even_sel"}, {15'd0, bus.issue_even_sel}, {15'd0, es});
        chk({tag, ".odd_vld"},  {15'd0, bus.issue_odd_vld},  {15'd0, ov});
        chk({tag, ".odd_sel"},  {15'd0, bus.issue_odd_sel},  {15'd0, os});
        chk({tag, ".br_first"}, {15'd0, bus.br_first_isntr}, {15'd0, br});
        chk({tag, ".ready"},    {15'd0, bus.pair_ready},     {15'd0, pr});
    endtask

    task automatic set_i0(input logic pipe, input logic wr, input logic [6:0] rt, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] su,
                          input logic [2:0] lat, input logic br);
        bus.inst0_pipe = pipe; bus.inst0_wr = wr; bus.inst0_rt = rt; bus.inst0_ra = ra;
        bus.inst0_rb = rb; bus.inst0_rc = rc; bus.inst0_src_use = su; bus.inst0_lat = lat;
        bus.inst0_is_branch = br;
    endtask

    task automatic set_i1(input logic pipe, input logic wr, input logic [6:0] rt, input logic [6:0] ra,
                          input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] su,
                          input logic [2:0] lat);
        bus.inst1_pipe = pipe; bus.inst1_wr = wr; bus.inst1_rt = rt; bus.inst1_ra = ra;
        bus.inst1_rb = rb; bus.inst1_rc = rc; bus.inst1_src_use = su; bus.inst1_lat = lat;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        cyc();
        cyc();
        chk_iss("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.stall", bus.stall_cycles, 16'd0);

        // Test 1: independent even add + odd load, dual issue the cycle after accept.
        @(negedge clk);
        reset = 1'b1;
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd1, 7'd10, 7'd11, 7'd12, 3'b110, 3'd1, 1'b0);
        set_i1(1'b1, 1'b1, 7'd5, 7'd20, 7'd21, 7'd22, 3'b111, 3'd2);
        #1;
        chk_iss("t1_acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t1_iss", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Test 2: both on the even pipe -> split, inst1 follows with even_sel=1.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b0);
        set_i1(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t2_n", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_iss("t2_n1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_stall", bus.stall_cycles, 16'd0);

        // Test 3: r2 written with lat=3 in cycle N; dependent pair issues in N+4.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd2, 7'd0, 7'd0, 7'd0, 3'b000, 3'd3, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        cyc();
        set_i0(1'b0, 1'b0, 7'd0, 7'd2, 7'd0, 7'd0, 3'b100, 3'd0, 1'b0);
        #0 chk_iss("t3_a", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t3_n1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("t3_n2.even_vld", {15'd0, bus.issue_even_vld}, 16'd0);
        cyc();
        chk("t3_n3.even_vld", {15'd0, bus.issue_even_vld}, 16'd0);
        cyc();
        chk_iss("t3_n4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_stall", bus.stall_cycles, 16'd3);

        // Test 4a: RAW inside the pair on r3 -> inst1 one cycle later on odd.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd0, 7'd3, 7'd0, 3'b010, 3'd0);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t4_raw_n", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        // Test 4b: WAW pair on r7 offered while the RAW remainder issues.
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1, 1'b0);
        set_i1(1'b1, 1'b1, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000, 3'd1);
        #0 chk_iss("t4_raw_n1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t4_waw_n", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_iss("t4_waw_n1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_stall", bus.stall_cycles, 16'd3);

        // Test 5a: branch first on odd, inst1 on even -> dual issue with br_first_isntr.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b1);
        set_i1(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t5_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Test 5b: RAW split, then flush while in ONE with a pair offered.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd9, 7'd0, 7'd0, 3'b100, 3'd0);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t5_split", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.flush = 1'b1;
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        #0 chk_iss("t5_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.flush = 1'b0;
        bus.pair_valid = 1'b0;
        #0 chk_iss("t5_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_stall", bus.stall_cycles, 16'd3);

        // Test 6: reset mid-stall with r4 busy (lat=5) clears everything.
        cyc();
        bus.pair_valid = 1'b1;
        set_i0(1'b0, 1'b1, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000, 3'd5, 1'b0);
        set_i1(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 3'd0);
        cyc();
        set_i0(1'b0, 1'b0, 7'd0, 7'd4, 7'd0, 7'd0, 3'b100, 3'd0, 1'b0);
        #0 chk_iss("t6_prod", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t6_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_stall_cnt", bus.stall_cycles, 16'd3);
        cyc();
        reset = 1'b0;
        #0 chk_iss("t6_rst_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_stall_cnt2", bus.stall_cycles, 16'd4);
        cyc();
        reset = 1'b1;
        bus.pair_valid = 1'b1;
        #0 chk_iss("t6_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_post_stall", bus.stall_cycles, 16'd0);
        cyc();
        bus.pair_valid = 1'b0;
        #0 chk_iss("t6_r4_ready", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
